// File: rtl/nec_ir_decoder_if.sv
// rtl/nec_ir_decoder_if.sv - IR line in, decoded word and event pulses out
interface nec_ir_decoder_if;
    logic        ir;
    logic [15:0] data;
    logic        valid;
    logic        rpt;
    logic        err;

    modport master (output ir, input data, input valid, input rpt, input err);
    modport slave  (input ir, output data, output valid, output rpt, output err);
endinterface

// File: rtl/nec_ir_decoder.sv
// rtl/nec_ir_decoder.sv - NEC IR frame decoder: width measurement, FSM, frame check
module nec_ir_decoder #(
    parameter int TICK_CYCLES = 600,
    parameter bit CHECK_ADDR  = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    nec_ir_decoder_if.slave bus
);
    localparam int            PW         = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_CYCLES - 1);

    localparam logic [7:0] LEAD_MK_MIN = 8'd160, LEAD_MK_MAX = 8'd200;
    localparam logic [7:0] FRM_SP_MIN  = 8'd80,  FRM_SP_MAX  = 8'd100;
    localparam logic [7:0] RPT_SP_MIN  = 8'd36,  RPT_SP_MAX  = 8'd54;
    localparam logic [7:0] MK_MIN      = 8'd8,   MK_MAX      = 8'd14;
    localparam logic [7:0] ONE_SP_MIN  = 8'd28,  ONE_SP_MAX  = 8'd40;

    typedef enum logic [2:0] {
        IDLE,
        LEAD_MK,
        LEAD_SP,
        BIT_MK,
        BIT_SP,
        STOP_MK
    } state_t;

    state_t        state_q, state_d;
    logic [1:0]    sync_q, sync_d;
    logic          prev_q, prev_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [7:0]    tick_cnt_q, tick_cnt_d;
    logic [5:0]    bit_cnt_q, bit_cnt_d;
    logic [31:0]   shift_q, shift_d;
    logic          rpt_flag_q, rpt_flag_d;
    logic          have_frame_q, have_frame_d;
    logic [15:0]   data_q, data_d;
    logic          valid_q, valid_d;
    logic          rpt_q, rpt_d;
    logic          err_q, err_d;

    logic       fall, rise, tick, timeout, frame_ok;
    logic [7:0] phase_max;
    logic [7:0] f_addr, f_addr_inv, f_cmd, f_cmd_inv;

    function automatic logic in_win(input logic [7:0] v, input logic [7:0] lo, input logic [7:0] hi);
        return (v >= lo) && (v <= hi);
    endfunction

    assign f_addr     = shift_q[7:0];
    assign f_addr_inv = shift_q[15:8];
    assign f_cmd      = shift_q[23:16];
    assign f_cmd_inv  = shift_q[31:24];
    assign frame_ok   = (f_cmd_inv == ~f_cmd) && (!CHECK_ADDR || (f_addr_inv == ~f_addr));

    assign fall = prev_q & ~sync_q[1];
    assign rise = ~prev_q & sync_q[1];
    assign tick = (presc_q == PRESC_LAST);

    always_comb begin
        phase_max = 8'd255;
        case (state_q)
            LEAD_MK: phase_max = LEAD_MK_MAX;
            LEAD_SP: phase_max = FRM_SP_MAX;
            BIT_MK:  phase_max = MK_MAX;
            BIT_SP:  phase_max = ONE_SP_MAX;
            STOP_MK: phase_max = MK_MAX;
            default: phase_max = 8'd255;
        endcase
    end

    // A real edge in the same cycle as the overflowing tick is judged on its width instead
    assign timeout = (state_q != IDLE) && tick && !(fall || rise) && (tick_cnt_q >= phase_max);

    always_comb begin
        sync_d       = {sync_q[0], bus.ir};
        prev_d       = sync_q[1];
        presc_d      = tick ? '0 : presc_q + 1'b1;
        tick_cnt_d   = tick_cnt_q;
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        rpt_flag_d   = rpt_flag_q;
        have_frame_d = have_frame_q;
        data_d       = data_q;
        valid_d      = 1'b0;
        rpt_d        = 1'b0;
        err_d        = 1'b0;

        if (fall || rise) begin
            tick_cnt_d = 8'd0;
        end else if (tick && (tick_cnt_q != 8'd255)) begin
            tick_cnt_d = tick_cnt_q + 8'd1;
        end

        if (timeout) begin
            err_d   = 1'b1;
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (fall) begin
                        state_d    = LEAD_MK;
                        bit_cnt_d  = 6'd0;
                        rpt_flag_d = 1'b0;
                    end
                end
                LEAD_MK: begin
                    if (rise) begin
                        if (in_win(tick_cnt_q, LEAD_MK_MIN, LEAD_MK_MAX)) begin
                            state_d = LEAD_SP;
                        end else begin
                            err_d   = 1'b1;
                            state_d = IDLE;
                        end
                    end
                end
                LEAD_SP: begin
                    if (fall) begin
                        if (in_win(tick_cnt_q, FRM_SP_MIN, FRM_SP_MAX)) begin
                            state_d = BIT_MK;
                        end else if (in_win(tick_cnt_q, RPT_SP_MIN, RPT_SP_MAX)) begin
                            state_d    = STOP_MK;
                            rpt_flag_d = 1'b1;
                        end else begin
                            err_d   = 1'b1;
                            state_d = IDLE;
                        end
                    end
                end
                BIT_MK: begin
                    if (rise) begin
                        if (in_win(tick_cnt_q, MK_MIN, MK_MAX)) begin
                            state_d = BIT_SP;
                        end else begin
                            err_d   = 1'b1;
                            state_d = IDLE;
                        end
                    end
                end
                BIT_SP: begin
                    if (fall) begin
                        if (in_win(tick_cnt_q, ONE_SP_MIN, ONE_SP_MAX) ||
                            in_win(tick_cnt_q, MK_MIN, MK_MAX)) begin
                            // LSB arrives first, so after 32 shifts bit 0 lands in shift_q[0]
                            shift_d   = {in_win(tick_cnt_q, ONE_SP_MIN, ONE_SP_MAX), shift_q[31:1]};
                            bit_cnt_d = bit_cnt_q + 6'd1;
                            state_d   = (bit_cnt_q == 6'd31) ? STOP_MK : BIT_MK;
                        end else begin
                            err_d   = 1'b1;
                            state_d = IDLE;
                        end
                    end
                end
                STOP_MK: begin
                    if (rise) begin
                        state_d = IDLE;
                        if (!in_win(tick_cnt_q, MK_MIN, MK_MAX)) begin
                            err_d = 1'b1;
                        end else if (rpt_flag_q) begin
                            rpt_d = have_frame_q;
                            err_d = !have_frame_q;
                        end else if (frame_ok) begin
                            data_d       = {f_addr, f_cmd};
                            valid_d      = 1'b1;
                            have_frame_d = 1'b1;
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            sync_q       <= 2'b11;
            prev_q       <= 1'b1;
            presc_q      <= '0;
            tick_cnt_q   <= 8'd0;
            bit_cnt_q    <= 6'd0;
            shift_q      <= 32'd0;
            rpt_flag_q   <= 1'b0;
            have_frame_q <= 1'b0;
            data_q       <= 16'd0;
            valid_q      <= 1'b0;
            rpt_q        <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            sync_q       <= sync_d;
            prev_q       <= prev_d;
            presc_q      <= presc_d;
            tick_cnt_q   <= tick_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            rpt_flag_q   <= rpt_flag_d;
            have_frame_q <= have_frame_d;
            data_q       <= data_d;
            valid_q      <= valid_d;
            rpt_q        <= rpt_d;
            err_q        <= err_d;
        end
    end

    assign bus.data  = data_q;
    assign bus.valid = valid_q;
    assign bus.rpt   = rpt_q;
    assign bus.err   = err_q;
endmodule

// File: tb/tb_nec_ir_decoder.sv
// tb/tb_nec_ir_decoder.sv - randomized NEC waveforms against a frame-level reference model
module tb_nec_ir_decoder;
    localparam int T = 2;

    logic clk    = 1'b0;
    logic rst_n  = 1'b0;
    logic ir_drv = 1'b1;

    always #5 clk = ~clk;

    nec_ir_decoder_if ifa ();
    nec_ir_decoder_if ifb ();
    assign ifa.ir = ir_drv;
    assign ifb.ir = ir_drv;

    nec_ir_decoder #(.TICK_CYCLES(T), .CHECK_ADDR(1'b1)) u_a (.clk(clk), .rst_n(rst_n), .bus(ifa.slave));
    nec_ir_decoder #(.TICK_CYCLES(T), .CHECK_ADDR(1'b0)) u_b (.clk(clk), .rst_n(rst_n), .bus(ifb.slave));

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: per decoder (0 = strict address, 1 = extended NEC)
    logic [15:0] m_data [2];
    bit          m_have [2];
    logic [2:0]  m_code [2];
    int          m_v [2], m_r [2], m_e [2];
    int          s_v [2], s_r [2], s_e [2];
    int          excl_viol = 0;

    initial begin
        for (int i = 0; i < 2; i++) begin
            m_data[i] = 16'h0; m_have[i] = 1'b0; m_code[i] = 3'b000;
            m_v[i] = 0; m_r[i] = 0; m_e[i] = 0;
            s_v[i] = 0; s_r[i] = 0; s_e[i] = 0;
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (ifa.valid) s_v[0]++;
            if (ifa.rpt)   s_r[0]++;
            if (ifa.err)   s_e[0]++;
            if (ifb.valid) s_v[1]++;
            if (ifb.rpt)   s_r[1]++;
            if (ifb.err)   s_e[1]++;
            if ($countones({ifa.valid, ifa.rpt, ifa.err}) > 1) excl_viol++;
            if ($countones({ifb.valid, ifb.rpt, ifb.err}) > 1) excl_viol++;
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    function automatic logic [2:0] got(input int i);
        return (i == 0) ? {ifa.valid, ifa.rpt, ifa.err} : {ifb.valid, ifb.rpt, ifb.err};
    endfunction

    function automatic logic [15:0] got_data(input int i);
        return (i == 0) ? ifa.data : ifb.data;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_data[i] = 16'h0;
            m_have[i] = 1'b0;
        end
    endtask

    task automatic predict_frame(input logic [7:0] a, input logic [7:0] ai, input logic [7:0] c, input logic [7:0] ci);
        for (int i = 0; i < 2; i++) begin
            if ((ci == ~c) && (i == 1 || ai == ~a)) m_code[i] = 3'b100;
            else                                    m_code[i] = 3'b001;
        end
    endtask

    task automatic predict_repeat();
        for (int i = 0; i < 2; i++) m_code[i] = m_have[i] ? 3'b010 : 3'b001;
    endtask

    task automatic hold(input logic lvl, input int ticks);
        ir_drv = lvl;
        repeat (ticks * T) @(negedge clk);
    endtask

    task automatic send_leader(input bit rep);
        hold(1'b0, $urandom_range(199, 161));
        if (rep) hold(1'b1, $urandom_range(53, 37));
        else     hold(1'b1, $urandom_range(99, 81));
    endtask

    task automatic send_bits(input logic [31:0] w, input int first, input int last);
        for (int k = first; k <= last; k++) begin
            hold(1'b0, $urandom_range(13, 9));
            if (w[k]) hold(1'b1, $urandom_range(39, 29));
            else      hold(1'b1, $urandom_range(13, 9));
        end
    endtask

    // Releases the line and expects the predicted pulse exactly on the 3rd clock after it
    task automatic check_release(input string name, input logic [7:0] a, input logic [7:0] c);
        ir_drv = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            @(posedge clk);
            #1;
            for (int i = 0; i < 2; i++) begin
                logic [2:0] want;
                want = (k == 3) ? m_code[i] : 3'b000;
                n_cmp++;
                if (got(i) !== want) begin
                    n_bad++;
                    $display("FAIL %s dut%0d clk+%0d: {valid,rpt,err} got %b want %b", name, i, k, got(i), want);
                end
            end
        end
        for (int i = 0; i < 2; i++) begin
            case (m_code[i])
                3'b100: begin m_data[i] = {a, c}; m_have[i] = 1'b1; m_v[i]++; end
                3'b010: m_r[i]++;
                default: m_e[i]++;
            endcase
            n_cmp++;
            if (got_data(i) !== m_data[i]) begin
                n_bad++;
                $display("FAIL %s_data dut%0d: got %h want %h", name, i, got_data(i), m_data[i]);
            end
        end
        @(negedge clk);
    endtask

    task automatic send_frame(input string name, input logic [7:0] a, input logic [7:0] ai,
                              input logic [7:0] c, input logic [7:0] ci, input int gap);
        predict_frame(a, ai, c, ci);
        send_leader(1'b0);
        send_bits({ci, c, ai, a}, 0, 31);
        hold(1'b0, $urandom_range(13, 9));
        check_release(name, a, c);
        hold(1'b1, gap);
    endtask

    task automatic send_repeat(input string name, input int gap);
        predict_repeat();
        send_leader(1'b1);
        hold(1'b0, $urandom_range(13, 9));
        check_release(name, 8'h00, 8'h00);
        hold(1'b1, gap);
    endtask

    task automatic check_outputs_zero(input string name);
        for (int i = 0; i < 2; i++) begin
            n_cmp++;
            if ({got_data(i), got(i)} !== 19'h0) begin
                n_bad++;
                $display("FAIL %s dut%0d: data/pulses got %h/%b want 0000/000", name, i, got_data(i), got(i));
            end
        end
    endtask

    task automatic check_totals(input string name);
        for (int i = 0; i < 2; i++) begin
            n_cmp++;
            if ({s_v[i], s_r[i], s_e[i]} !== {m_v[i], m_r[i], m_e[i]}) begin
                n_bad++;
                $display("FAIL %s dut%0d: valid/rpt/err counts got %0d/%0d/%0d want %0d/%0d/%0d",
                         name, i, s_v[i], s_r[i], s_e[i], m_v[i], m_r[i], m_e[i]);
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (4) @(negedge clk);
        check_outputs_zero("reset_state");
        rst_n = 1'b1;
        model_reset();
        hold(1'b1, 20);
    endtask

    task automatic test_frame();
        send_frame("nec_frame", 8'h00, 8'hFF, 8'h45, 8'hBA, 30);
    endtask

    task automatic test_repeat();
        send_repeat("repeat_code", 30);
    endtask

    task automatic test_checksum();
        send_frame("cmd_inv_bad", 8'h10, 8'hEF, 8'h22, 8'hDC, 30);
        send_frame("addr_inv_ext", 8'h10, 8'h00, 8'h22, 8'hDD, 30);
    endtask

    task automatic test_bad_leader();
        int  cyc;
        bit  found;
        m_code[0] = 3'b001;
        m_code[1] = 3'b001;
        hold(1'b0, 100);
        check_release("short_leader", 8'h00, 8'h00);
        hold(1'b1, 30);

        ir_drv = 1'b0;
        cyc    = 0;
        found  = 1'b0;
        while (!found && cyc < 250 * T) begin
            @(posedge clk);
            #1;
            cyc++;
            if (ifa.err && ifb.err) found = 1'b1;
        end
        n_cmp++;
        if (!found || cyc < 200 * T || cyc > 203 * T + 4) begin
            n_bad++;
            $display("FAIL leader_timeout: err seen=%0d after %0d clk, want within %0d..%0d", found, cyc, 200 * T, 203 * T + 4);
        end
        m_e[0]++;
        m_e[1]++;
        @(negedge clk);
        hold(1'b0, 40);
        hold(1'b1, 30);
        check_totals("stuck_low_quiet");
    endtask

    task automatic test_repeat_no_frame();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        hold(1'b1, 20);
        send_repeat("repeat_no_frame", 30);
    endtask

    task automatic test_reset_mid_frame();
        logic [31:0] w;
        send_frame("pre_reset", 8'h3C, 8'hC3, 8'h81, 8'h7E, 30);
        w = {$urandom()};
        send_leader(1'b0);
        send_bits(w, 0, 16);
        ir_drv = 1'b0;
        repeat (3 * T) @(negedge clk);
        #3 rst_n = 1'b0;
        #1 check_outputs_zero("reset_mid_frame");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        // Each remaining mark now looks like a too-short leader: bit 17 tail, bits 18..31, stop
        hold(1'b0, 5);
        if (w[17]) hold(1'b1, 33); else hold(1'b1, 11);
        send_bits(w, 18, 31);
        hold(1'b0, 11);
        hold(1'b1, 30);
        m_e[0] += 16;
        m_e[1] += 16;
        check_totals("partial_after_reset");
        send_frame("post_reset", 8'hA5, 8'h5A, 8'h0F, 8'hF0, 30);
    endtask

    task automatic test_back_to_back();
        for (int n = 0; n < 8; n++) begin
            logic [7:0] a, ai, c, ci;
            int         sel;
            a   = 8'($urandom());
            c   = 8'($urandom());
            ai  = ~a;
            ci  = ~c;
            sel = $urandom_range(5, 0);
            if (sel == 1) ci = ~c ^ (8'h01 << $urandom_range(7, 0));
            if (sel == 2) ai = ~a ^ (8'h01 << $urandom_range(7, 0));
            if (sel == 0) send_repeat("rand_repeat", $urandom_range(15, 3));
            else          send_frame("rand_frame", a, ai, c, ci, $urandom_range(15, 3));
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_frame();
        test_repeat();
        test_checksum();
        test_bad_leader();
        test_repeat_no_frame();
        test_reset_mid_frame();
        test_back_to_back();
        check_totals("event_totals");
        n_cmp++;
        if (excl_viol !== 0) begin
            n_bad++;
            $display("FAIL pulse_exclusive: overlapping pulses got %0d want 0", excl_viol);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
